// File: rtl/fcount_latch_if.sv
// Signal/control bundle for the gated BCD frequency counter.
// The master side drives the signal and the gate strobes; the slave side returns the latched result.
interface fcount_latch_if #(
   parameter int DIGITS = 6
);
   logic                  sig_in;
   logic                  en_count;
   logic                  en_latch;
   logic [4*DIGITS-1:0]   freq_bcd;
   logic                  valid;
   logic                  ovf;

   modport master (
      output sig_in, en_count, en_latch,
      input  freq_bcd, valid, ovf
   );

   modport slave (
      input  sig_in, en_count, en_latch,
      output freq_bcd, valid, ovf
   );
endinterface

// File: rtl/fcount_latch.sv
// Gated BCD edge counter: counts synchronised rising edges of sig_in and latches the count at window end.
// Build option FCOUNT_SAT_EN: saturate the counter at all nines instead of wrapping to zero.
module fcount_latch #(
   parameter int DIGITS = 6
) (
   input  logic          clk,
   input  logic          nCR,
   fcount_latch_if.slave bus
);
   localparam int W = 4 * DIGITS;

   typedef enum logic {WAIT_CLR = 1'b0, COUNT = 1'b1} state_t;

   state_t          state_reg;
   logic            s1_reg, s2_reg, s3_reg;
   logic [W-1:0]    cnt_reg;
   logic [W-1:0]    cnt_inc;
   logic [W-1:0]    cnt_next;
   logic            ovf_int_reg;
   logic            ovf_int_next;
   logic [W-1:0]    freq_reg;
   logic            valid_reg;
   logic            ovf_reg;
   logic [DIGITS:0] carry;
   logic            rise;
   logic            all_nines;

   assign rise = s2_reg & ~s3_reg;

   // Ripple the +1 through the digits; a carry out of the top digit means the count was all nines.
   assign carry[0] = 1'b1;
   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
         logic [3:0] d;
         assign d                  = cnt_reg[4*gi +: 4];
         assign carry[gi+1]        = carry[gi] & (d == 4'd9);
         assign cnt_inc[4*gi +: 4] = !carry[gi]   ? d     :
                                     (d == 4'd9)  ? 4'd0  : d + 4'd1;
      end
   endgenerate
   assign all_nines = carry[DIGITS];

   always_comb begin
      cnt_next     = cnt_reg;
      ovf_int_next = ovf_int_reg;
      if (rise) begin
         ovf_int_next = ovf_int_reg | all_nines;
`ifdef FCOUNT_SAT_EN
         if (!all_nines) begin
            cnt_next = cnt_inc;
         end
`else
         cnt_next = cnt_inc;
`endif
      end
   end

   always_ff @(posedge clk or negedge nCR) begin
      if (!nCR) begin
         s1_reg      <= 1'b0;
         s2_reg      <= 1'b0;
         s3_reg      <= 1'b0;
         cnt_reg     <= '0;
         ovf_int_reg <= 1'b0;
         freq_reg    <= '0;
         valid_reg   <= 1'b0;
         ovf_reg     <= 1'b0;
         state_reg   <= WAIT_CLR;
      end else begin
         s1_reg    <= bus.sig_in;
         s2_reg    <= s1_reg;
         s3_reg    <= s2_reg;
         valid_reg <= 1'b0;
         if (!bus.en_count) begin
            // Clear wins over counting; a coincident latch publishes the pre-clear window without the rise.
            if (state_reg == COUNT && bus.en_latch) begin
               freq_reg  <= cnt_reg;
               ovf_reg   <= ovf_int_reg;
               valid_reg <= 1'b1;
            end
            cnt_reg     <= '0;
            ovf_int_reg <= 1'b0;
            state_reg   <= COUNT;
         end else begin
            cnt_reg     <= cnt_next;
            ovf_int_reg <= ovf_int_next;
            if (state_reg == COUNT && bus.en_latch) begin
               freq_reg  <= cnt_next;
               ovf_reg   <= ovf_int_next;
               valid_reg <= 1'b1;
            end
         end
      end
   end

   assign bus.freq_bcd = freq_reg;
   assign bus.valid    = valid_reg;
   assign bus.ovf      = ovf_reg;
endmodule

// File: doc/fcount_latch.md
FCOUNT_LATCH -- requirements
Module: fcount_latch

Interface
REQ-001 Parameter DIGITS, default 6: number of BCD digits in the edge counter and result register.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 nCR  input  1  asynchronous, active-low reset.
REQ-004 sig_in  input  1  measured signal, asynchronous to clk.
REQ-005 en_count  input  1  gate-window clear strobe, active-low, one clk cycle wide, synchronous to clk.
REQ-006 en_latch  input  1  gate-window end strobe, active-high, one clk cycle wide, synchronous to clk.
REQ-007 freq_bcd  output  4*DIGITS  latched edge count of the last complete window, packed BCD with the least significant digit in bits [3:0].
REQ-008 valid  output  1  one-cycle pulse in the cycle after freq_bcd updates.
REQ-009 ovf  output  1  overflow flag for the value currently on freq_bcd.

Function
REQ-010 sig_in SHALL pass through a 3-flop chain s1->s2->s3, with rise = s2 & ~s3.
REQ-011 When rise=1, cnt SHALL increment by one on that clk edge, as BCD with per-digit carry 9->0.
- Latency from a sig_in rise (meeting setup) to the cnt increment: 3 rising edges of clk.
REQ-012 Correct counting SHALL be guaranteed only when sig_in high time and low time are each at least 2 clk periods.
REQ-013 FSM with two states: WAIT_CLR (reset state) and COUNT.
REQ-014 en_count=0 in either state SHALL set cnt to 0, clear ovf_int and move to COUNT; a rise in the same cycle is dropped.
REQ-015 en_latch=1 in COUNT SHALL update the outputs on that edge:
- freq_bcd <= cnt, including a rise in the same cycle (cnt+1);
- ovf <= ovf_int, including an overflow caused by that rise.
REQ-016 en_latch=1 in WAIT_CLR SHALL leave freq_bcd, ovf and valid unchanged, because the partial window is discarded.
REQ-017 valid SHALL be 1 for exactly the one cycle after each freq_bcd update, and 0 otherwise.
REQ-018 en_count=0 and en_latch=1 in the same cycle in COUNT:
- freq_bcd and ovf take the pre-clear values;
- cnt then clears;
- the state stays COUNT.
REQ-019 Between latches, freq_bcd and ovf SHALL hold their values; counting does not affect them.
REQ-020 cnt SHALL keep counting across en_latch unless en_count is also asserted, so that a free-running gate remains consistent.

Reset
REQ-021 nCR=0 SHALL immediately force:
- s1, s2, s3 and cnt to 0;
- ovf_int to 0;
- freq_bcd to 0, valid to 0 and ovf to 0;
- state to WAIT_CLR.
REQ-022 After nCR deasserts, no result SHALL be produced until the first en_count=0 followed by an en_latch=1.
REQ-023 A reset in the middle of a window SHALL discard that window entirely.

Configuration
REQ-024 With macro FCOUNT_SAT_EN defined, a rise when cnt is all nines SHALL:
- hold cnt at all nines;
- set ovf_int, which stays set until en_count or reset.
REQ-025 Without FCOUNT_SAT_EN, a rise when cnt is all nines SHALL:
- wrap cnt to 0;
- set ovf_int, which stays set until en_count or reset.
- Port list and all other behaviour are identical in both builds.

Verification
REQ-026 Reset only, then en_latch pulse without a prior en_count -> freq_bcd=0, valid never asserts, ovf=0.
REQ-027 Setup: en_count low at cycle 1; 1234 sig_in rises, period 4 clk; en_latch at cycle 5500.
- Required response: freq_bcd=0x001234, valid high for 1 cycle, ovf=0.
REQ-028 Setup: rise detected in the same cycle as en_latch, with 99 earlier rises.
- Required response: freq_bcd=0x000100.
- With en_count also low in that cycle: freq_bcd=0x000099, and the next window starts from 0.
REQ-029 Setup: DIGITS=2, 105 rises in the window.
- With FCOUNT_SAT_EN: freq_bcd=0x99, ovf=1.
- Without FCOUNT_SAT_EN: freq_bcd=0x05, ovf=1.
- The next window with 3 rises gives freq_bcd=0x03, ovf=0.
REQ-030 Setup: nCR pulsed low mid-window after 500 rises.
- Required response: all outputs 0 immediately.
- The following en_latch before any en_count gives no valid pulse.
- The next full window with 7 rises gives freq_bcd=0x000007.
